// File: rtl/i2s_dac_tx.sv
// Stereo I2S master transmitter: BCLK/LRCK generation, one-bit-delayed
// MSB-first serialization of double-buffered 16-bit L/R sample pairs.
module i2s_dac_tx #(
   parameter int BCLK_HALF = 8,
   parameter int SLOT_BITS = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] Sample_L,
   input  logic [15:0] Sample_R,
   input  logic        Sample_valid,
   output logic        Sample_ready,
   output logic        BCLK,
   output logic        LRCK,
   output logic        DACDAT,
   output logic        Frame_start,
   output logic        Underrun
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int DW = $clog2(BCLK_HALF);
   localparam int BW = $clog2(FRAME_BITS);

   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);
   localparam logic [BW-1:0] MSB_POS  = BW'(1);
   localparam logic [BW-1:0] LSB_POS  = BW'(16);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic          bclk_q, bclk_d;
   logic          lrck_q, lrck_d;
   logic          dacdat_q, dacdat_d;
   logic          frame_start_q, frame_start_d;
   logic          underrun_q, underrun_d;
   logic          full_q, full_d;
   logic [15:0]   hold_l_q, hold_l_d;
   logic [15:0]   hold_r_q, hold_r_d;
   logic [15:0]   sh_l_q, sh_l_d;
   logic [15:0]   sh_r_q, sh_r_d;

   logic          div_wrap;
   logic          fall;
   logic          load;
   logic          accept;
   logic          in_right;
   logic          data_slot;
   logic [BW-1:0] slot_k;

   // Bit timing: the divider wrap toggles BCLK, a falling toggle steps bit_cnt.
   always_comb begin
      div_wrap  = (div_cnt_q == DIV_LAST);
      fall      = div_wrap & bclk_q;
      load      = fall & (bit_cnt_q == BIT_LAST);
      accept    = Sample_valid & ~full_q;
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
      bclk_d    = bclk_q ^ div_wrap;
      bit_cnt_d = bit_cnt_q;
      if (fall) begin
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      end
      in_right  = (bit_cnt_d >= SLOT_LEN);
      slot_k    = in_right ? bit_cnt_d - SLOT_LEN : bit_cnt_d;
      data_slot = (slot_k >= MSB_POS) && (slot_k <= LSB_POS);
   end

   always_comb begin
      lrck_d        = lrck_q;
      dacdat_d      = dacdat_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      full_d        = full_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      sh_l_d        = sh_l_q;
      sh_r_d        = sh_r_q;

      if (fall) begin
         lrck_d   = in_right;
         dacdat_d = 1'b0;
         if (data_slot && in_right) begin
            dacdat_d = sh_r_q[15];
            sh_r_d   = {sh_r_q[14:0], 1'b0};
         end else if (data_slot) begin
            dacdat_d = sh_l_q[15];
            sh_l_d   = {sh_l_q[14:0], 1'b0};
         end
      end

      // Load lands on slot offset 0, so it never collides with a shift.
      if (load) begin
         frame_start_d = 1'b1;
         if (full_q) begin
            sh_l_d = hold_l_q;
            sh_r_d = hold_r_q;
            full_d = 1'b0;
         end else if (accept) begin
            sh_l_d = Sample_L;
            sh_r_d = Sample_R;
         end else begin
            sh_l_d     = '0;
            sh_r_d     = '0;
            underrun_d = 1'b1;
         end
      end else if (accept) begin
         hold_l_d = Sample_L;
         hold_r_d = Sample_R;
         full_d   = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_cnt_q     <= '0;
         bit_cnt_q     <= BIT_LAST;
         bclk_q        <= 1'b0;
         lrck_q        <= 1'b0;
         dacdat_q      <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         full_q        <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         sh_l_q        <= '0;
         sh_r_q        <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         bclk_q        <= bclk_d;
         lrck_q        <= lrck_d;
         dacdat_q      <= dacdat_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         full_q        <= full_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         sh_l_q        <= sh_l_d;
         sh_r_q        <= sh_r_d;
      end
   end

   assign Sample_ready = ~full_q;
   assign BCLK         = bclk_q;
   assign LRCK         = lrck_q;
   assign DACDAT       = dacdat_q;
   assign Frame_start  = frame_start_q;
   assign Underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx at default and minimum parameters: frame-level
// reference model feeding a queue, serial monitor decoding each frame.
module tb_i2s_dac_tx;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      bit          ur;
   } frame_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input int id, input string nm,
                      input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL cfg%0d %s: got %0h expected %0h at %0t",
                  id, nm, got, exp, $time);
      end
   endtask

   task automatic fail_msg(input int id, input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL cfg%0d %s at %0t", id, nm, $time);
   endtask

   for (genvar G = 0; G < 2; G++) begin : g_cfg
      localparam int BH  = (G == 0) ? 8 : 2;
      localparam int SB  = (G == 0) ? 32 : 17;
      localparam int F0  = 2 * BH;
      localparam int FC  = 4 * BH * SB;
      localparam int RB  = (SB > 20) ? 20 : 10;
      localparam int TMO = 3 * FC;

      logic        rst, sv, rdy, bclk, lrck, dacdat, fs, ur;
      logic [15:0] sl, sr;
      logic [15:0] hl, hr;
      frame_t      exp_q[$];
      int          cyc = 0;
      bit          started = 0;
      bit          mfull = 0;
      bit          done = 0;
      bit          ld, acc, exp_ur;

      i2s_dac_tx #(.BCLK_HALF(BH), .SLOT_BITS(SB)) dut (
         .Clk          (clk),
         .Reset        (rst),
         .Sample_L     (sl),
         .Sample_R     (sr),
         .Sample_valid (sv),
         .Sample_ready (rdy),
         .BCLK         (bclk),
         .LRCK         (lrck),
         .DACDAT       (dacdat),
         .Frame_start  (fs),
         .Underrun     (ur)
      );

      // Reference model: frame loads every FC cycles after the first fall.
      initial begin
         frame_t e;
         forever begin
            @(posedge clk);
            ld = 0;
            exp_ur = 0;
            if (rst) begin
               started = 1;
               mfull = 0;
               cyc = 0;
               exp_q.delete();
            end else if (started) begin
               cyc++;
               ld = (cyc >= F0) && ((cyc - F0) % FC == 0);
               acc = sv && !mfull;
               if (ld) begin
                  if (mfull) begin
                     e.l = hl; e.r = hr; e.ur = 0;
                     mfull = 0;
                  end else if (acc) begin
                     e.l = sl; e.r = sr; e.ur = 0;
                  end else begin
                     e.l = 0; e.r = 0; e.ur = 1;
                  end
                  exp_ur = e.ur;
                  exp_q.push_back(e);
               end else if (acc) begin
                  hl = sl;
                  hr = sr;
                  mfull = 1;
               end
            end
            #1;
            if (started) begin
               chk(G, "bclk", bclk, (cyc / BH) % 2);
               chk(G, "lrck", lrck, (cyc < F0) ? 0 :
                   ((((cyc - F0) / F0) % (2 * SB)) >= SB));
               chk(G, "sample_ready", rdy, !mfull);
               chk(G, "frame_start", fs, ld);
               chk(G, "underrun", ur, exp_ur);
               if (cyc < F0) chk(G, "dacdat_idle", dacdat, 0);
            end
         end
      end

      // Monitor: on each Frame_start, sample DACDAT at every BCLK rise.
      initial begin
         frame_t       e;
         logic [127:0] bits;
         logic [15:0]  gl, gr;
         logic         stray, prev, abort;
         int           n, t, k;
         forever begin
            @(posedge clk);
            #1;
            if (started && !rst && fs) begin
               if (exp_q.size() == 0) begin
                  fail_msg(G, "frame_unexpected");
               end else begin
                  e = exp_q.pop_front();
                  chk(G, "frame_underrun", ur, e.ur);
                  bits = '0;
                  n = 0;
                  t = 0;
                  abort = 0;
                  prev = bclk;
                  while (n < 2 * SB && !abort) begin
                     @(posedge clk);
                     #1;
                     t++;
                     if (rst) begin
                        abort = 1;
                     end else begin
                        if (bclk && !prev) begin
                           bits[n] = dacdat;
                           n++;
                        end
                        prev = bclk;
                        if (t > FC + F0) begin
                           fail_msg(G, "bclk_rise_timeout");
                           abort = 1;
                        end
                     end
                  end
                  if (!abort) begin
                     gl = '0;
                     gr = '0;
                     stray = 0;
                     for (int i = 0; i < 2 * SB; i++) begin
                        k = i % SB;
                        if (k >= 1 && k <= 16) begin
                           if (i >= SB) gr[16-k] = bits[i];
                           else gl[16-k] = bits[i];
                        end else begin
                           stray = stray | bits[i];
                        end
                     end
                     chk(G, "left_word", gl, e.l);
                     chk(G, "right_word", gr, e.r);
                     chk(G, "pad_bits", stray, 0);
                  end
               end
            end
         end
      end

      task automatic wait_cyc(input int n);
         int t = 0;
         while (cyc < n && t < 4 * FC) begin
            @(negedge clk);
            t++;
         end
         if (cyc < n) fail_msg(G, "wait_timeout");
      endtask

      task automatic offer(input logic [15:0] l, input logic [15:0] r);
         int t = 0;
         sl = l;
         sr = r;
         sv = 1;
         while (!rdy && t < TMO) begin
            @(negedge clk);
            t++;
         end
         if (!rdy) fail_msg(G, "offer_timeout");
         @(negedge clk);
         sv = 0;
      endtask

      initial begin
         int lb;
         rst = 1;
         sv = 0;
         sl = '0;
         sr = '0;
         repeat (5) @(negedge clk);
         rst = 0;
         offer(16'hA5F0, 16'h0F5A);
         wait_cyc(F0 + 2 * FC + 4);
         repeat (3) offer(16'($urandom), 16'($urandom));
         wait_cyc(F0 + 6 * FC - 1);
         sl = 16'($urandom);
         sr = 16'($urandom);
         sv = 1;
         @(negedge clk);
         sv = 0;
         repeat (6) begin
            repeat ($urandom_range(0, FC)) @(negedge clk);
            offer(16'($urandom), 16'($urandom));
         end
         wait_cyc(cyc + 3 * FC);
         lb = F0 + ((cyc - F0) / FC + 1) * FC;
         wait_cyc(lb + 1);
         offer(16'($urandom), 16'($urandom));
         wait_cyc(lb + RB * F0 + BH);
         rst = 1;
         repeat (3) @(negedge clk);
         rst = 0;
         wait_cyc(F0 + 2 * FC + 4);
         done = 1;
      end
   end

   initial begin
      int t = 0;
      while (!(g_cfg[0].done && g_cfg[1].done) && t < 80000) begin
         @(negedge clk);
         t++;
      end
      if (!(g_cfg[0].done && g_cfg[1].done)) fail_msg(-1, "run_timeout");
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
